// File: rtl/uart_cfg_pkg.sv
// rtl/uart_cfg_pkg.sv - shared encodings and helpers for the config UART transmitter
// Purpose: parity_mode encodings, transmitter FSM state type and a frame-length helper.
package uart_cfg_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Total clock cycles occupied by one frame on the line.
  function automatic int unsigned frame_cycles(
    input int unsigned clk_div,
    input int unsigned data_bits,
    input int unsigned parity_bits,
    input int unsigned stop_bits,
    input int unsigned gap_bits
  );
    return (1 + data_bits + parity_bits + stop_bits + gap_bits) * clk_div;
  endfunction

endpackage

// File: rtl/uart_cfg_fifo.sv
// rtl/uart_cfg_fifo.sv - synchronous FIFO feeding the UART transmitter
// Purpose: small circular-buffer FIFO; head word is readable whenever non-empty.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   push_i, wdata_i   write strobe and data (ignored while full)
//   pop_i, rdata_o    read strobe (ignored while empty) and head word
//   full_o, empty_o   status flags
//   level_o           current occupancy
module uart_cfg_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Storage carries no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_cfg_tx.sv
// rtl/uart_cfg_tx.sv - buffered UART transmitter driving an eFPGA configuration Rx pin
// Purpose: pops words from an input FIFO and serialises them as start/data/parity/stop/gap frames.
// Ports:
//   CLK, resetn        clock, asynchronous active-low reset
//   in_data, in_valid  input word and its valid; in_ready = FIFO not full
//   parity_mode        0/3 none, 1 even, 2 odd; latched when a frame starts
//   Tx                 registered serial output, idle high
//   busy               frame in progress or FIFO holding data
//   fifo_level         FIFO occupancy
//   frames_sent        completed frames since reset, wrapping
module uart_cfg_tx
  import uart_cfg_pkg::*;
#(
  parameter int CLK_DIV    = 8,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 2,
  parameter int GAP_BITS   = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int COUNT_W    = 16
) (
  input  logic                        CLK,
  input  logic                        resetn,
  input  logic [DATA_BITS-1:0]        in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  parity_mode,
  output logic                        Tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [COUNT_W-1:0]          frames_sent
);

  // The stop+gap period is the longest single timer interval.
  localparam int TMR_MAX = (STOP_BITS + GAP_BITS) * CLK_DIV - 1;
  localparam int TW      = $clog2(TMR_MAX + 1);
  localparam int BW      = $clog2(DATA_BITS);

  localparam logic [TW-1:0] BIT_RELOAD  = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] STOP_RELOAD = TW'(TMR_MAX);
  localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_BITS - 1);

  tx_state_e            state_q;
  logic [TW-1:0]        tmr_q;
  logic [BW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_en_q;
  logic                 par_bit_q;
  logic                 tx_q;
  logic [COUNT_W-1:0]   cnt_q;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 tmr_done;
  logic                 pop;

  uart_cfg_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (resetn),
    .push_i  (in_valid),
    .wdata_i (in_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign tmr_done = (tmr_q == '0);
  // A new frame starts from IDLE, or straight out of the final stop/gap cycle.
  assign pop = !fifo_empty &&
               ((state_q == ST_IDLE) || ((state_q == ST_STOP) && tmr_done));

  assign in_ready    = !fifo_full;
  assign Tx          = tx_q;
  assign busy        = (state_q != ST_IDLE) || !fifo_empty;
  assign frames_sent = cnt_q;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
        end
        ST_START: begin
          if (tmr_done) begin
            state_q   <= ST_DATA;
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= '0;
            tmr_q     <= BIT_RELOAD;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        ST_DATA: begin
          if (tmr_done) begin
            if (bit_cnt_q == LAST_BIT) begin
              if (par_en_q) begin
                state_q <= ST_PARITY;
                tx_q    <= par_bit_q;
                tmr_q   <= BIT_RELOAD;
              end else begin
                state_q <= ST_STOP;
                tx_q    <= 1'b1;
                tmr_q   <= STOP_RELOAD;
              end
            end else begin
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q + 1'b1;
              tmr_q     <= BIT_RELOAD;
            end
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        ST_PARITY: begin
          if (tmr_done) begin
            state_q <= ST_STOP;
            tx_q    <= 1'b1;
            tmr_q   <= STOP_RELOAD;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        ST_STOP: begin
          if (tmr_done) begin
            cnt_q   <= cnt_q + 1'b1;
            state_q <= ST_IDLE;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
        end
      endcase

      // Frame load overrides whatever the state branch chose above, which
      // gives back-to-back frames with no idle cycle in between.
      if (pop) begin
        state_q   <= ST_START;
        tx_q      <= 1'b0;
        tmr_q     <= BIT_RELOAD;
        shift_q   <= fifo_rdata;
        par_en_q  <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
        par_bit_q <= (^fifo_rdata) ^ (parity_mode == PAR_ODD);
      end
    end
  end

endmodule

// File: tb/tb_uart_cfg_tx.sv
// tb/tb_uart_cfg_tx.sv - directed self-checking bench for uart_cfg_tx
module tb_uart_cfg_tx;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       resetn;
  logic [1:0] parity_mode;

  logic [7:0]  in_data0;
  logic        in_valid0;
  logic        in_ready0;
  logic        tx0;
  logic        busy0;
  logic [2:0]  lvl0;
  logic [15:0] fs0;

  logic [7:0]  in_data1;
  logic        in_valid1;
  logic        in_ready1;
  logic        tx1;
  logic        busy1;
  logic [2:0]  lvl1;
  logic [1:0]  fs1;

  logic [6:0]  in_data2;
  logic        in_valid2;
  logic        in_ready2;
  logic        tx2;
  logic        busy2;
  logic [2:0]  lvl2;
  logic [15:0] fs2;

  int checks = 0;
  int errors = 0;

  logic log0_tx[$];
  logic log0_busy[$];
  logic log2_tx[$];

  uart_cfg_tx dut0 (
    .CLK(CLK), .resetn(resetn), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .parity_mode(parity_mode), .Tx(tx0), .busy(busy0),
    .fifo_level(lvl0), .frames_sent(fs0)
  );

  uart_cfg_tx #(.COUNT_W(2)) dut1 (
    .CLK(CLK), .resetn(resetn), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .parity_mode(parity_mode), .Tx(tx1), .busy(busy1),
    .fifo_level(lvl1), .frames_sent(fs1)
  );

  uart_cfg_tx #(.DATA_BITS(7), .CLK_DIV(3), .STOP_BITS(1), .GAP_BITS(0)) dut2 (
    .CLK(CLK), .resetn(resetn), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .parity_mode(parity_mode), .Tx(tx2), .busy(busy2),
    .fifo_level(lvl2), .frames_sent(fs2)
  );

  // Entry k of each log holds the value seen just after rising edge k.
  always @(posedge CLK) begin
    #1;
    log0_tx.push_back(tx0);
    log0_busy.push_back(busy0);
    log2_tx.push_back(tx2);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line waveform from start bit through the last stop/gap cycle,
  // compared cycle-by-cycle against the log starting at index s.
  task automatic chk_frame(input string tag, input int which, input int s,
                           input logic [8:0] d, input int nd, input int c,
                           input bit has_par, input bit par, input int nstop);
    logic [127:0] e;
    logic [127:0] o;
    logic         b;
    int           p;
    int           nb;
    e  = '0;
    o  = '0;
    p  = 0;
    nb = 1 + nd + int'(has_par) + nstop;
    for (int k = 0; k < nb; k++) begin
      if (k == 0)                       b = 1'b0;
      else if (k <= nd)                 b = d[k-1];
      else if (has_par && (k == nd+1))  b = par;
      else                              b = 1'b1;
      for (int j = 0; j < c; j++) begin
        e[p] = b;
        if (which == 0) o[p] = (s + p < log0_tx.size()) ? log0_tx[s+p] : 1'bx;
        else            o[p] = (s + p < log2_tx.size()) ? log2_tx[s+p] : 1'bx;
        p++;
      end
    end
    chk(tag, o, e);
  endtask

  // Single push; returns the log index of the first start-bit cycle.
  task automatic push(input int which, input logic [7:0] d, output int s);
    case (which)
      0: begin chk("push_ready0", in_ready0, 1'b1); in_valid0 = 1'b1; in_data0 = d; end
      1: begin chk("push_ready1", in_ready1, 1'b1); in_valid1 = 1'b1; in_data1 = d; end
      default: begin chk("push_ready2", in_ready2, 1'b1); in_valid2 = 1'b1; in_data2 = d[6:0]; end
    endcase
    @(negedge CLK);
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    in_valid2 = 1'b0;
    s = log0_tx.size();
  endtask

  initial begin
    int         s;
    int         s2;
    int         s0;
    int         n_acc;
    bit         acc;
    logic [7:0] b3 [6];
    logic [1:0] fs_seq [5];

    b3     = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    fs_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    resetn      = 1'b0;
    parity_mode = 2'd0;
    in_valid0 = 1'b0; in_data0 = '0;
    in_valid1 = 1'b0; in_data1 = '0;
    in_valid2 = 1'b0; in_data2 = '0;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_tx", tx0, 1'b1);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_level", lvl0, 3'd0);
    chk("rst_frames", fs0, 16'd0);
    resetn = 1'b1;
    @(negedge CLK);
    chk("rel_ready", in_ready0, 1'b1);
    chk("rel_tx", tx0, 1'b1);

    // 1: 0xA5 no parity -> 0,1,0,1,0,0,1,0,1,1,1,1 x 8 cycles = 96
    parity_mode = 2'd0;
    push(0, 8'hA5, s);
    repeat (100) @(negedge CLK);
    chk("t1_pre_idle", log0_tx[s-1], 1'b1);
    chk_frame("t1_frame", 0, s, 9'h0A5, 8, 8, 1'b0, 1'b0, 3);
    chk("t1_post_idle", log0_tx[s+96], 1'b1);
    chk("t1_busy_push", log0_busy[s-1], 1'b1);
    chk("t1_busy_last", log0_busy[s+95], 1'b1);
    chk("t1_busy_fall", log0_busy[s+96], 1'b0);
    chk("t1_frames", fs0, 16'd1);

    // 2: even parity (bit 0), mode changed mid-frame
    parity_mode = 2'd1;
    push(0, 8'hA5, s);
    @(negedge CLK);
    parity_mode = 2'd2;
    repeat (108) @(negedge CLK);
    chk_frame("t2_even", 0, s, 9'h0A5, 8, 8, 1'b1, 1'b0, 3);
    chk("t2_even_end", log0_tx[s+104], 1'b1);
    chk("t2_even_busy", log0_busy[s+104], 1'b0);
    chk("t2_frames_a", fs0, 16'd2);

    // odd parity (bit 1)
    parity_mode = 2'd2;
    push(0, 8'hA5, s);
    @(negedge CLK);
    parity_mode = 2'd0;
    repeat (108) @(negedge CLK);
    chk_frame("t2_odd", 0, s, 9'h0A5, 8, 8, 1'b1, 1'b1, 3);
    chk("t2_frames_b", fs0, 16'd3);

    // mode 3 behaves as no parity
    parity_mode = 2'd3;
    push(0, 8'hA5, s);
    repeat (100) @(negedge CLK);
    chk_frame("t2_mode3", 0, s, 9'h0A5, 8, 8, 1'b0, 1'b0, 3);
    chk("t2_mode3_end", log0_busy[s+96], 1'b0);
    chk("t2_frames_c", fs0, 16'd4);

    // 3: six bytes back-to-back into a 4-deep FIFO
    parity_mode = 2'd0;
    n_acc = 0;
    s0 = 0;
    in_valid0 = 1'b1;
    in_data0  = b3[0];
    for (int cyc = 0; cyc < 300 && n_acc < 6; cyc++) begin
      acc = in_ready0;
      @(negedge CLK);
      if (acc) begin
        if (n_acc == 0) s0 = log0_tx.size();
        n_acc++;
        if (n_acc == 5) begin
          chk("t3_level_full", lvl0, 3'd4);
          chk("t3_ready_low", in_ready0, 1'b0);
        end
        if (n_acc < 6) in_data0 = b3[n_acc];
      end
    end
    in_valid0 = 1'b0;
    chk("t3_all_pushed", n_acc, 6);
    repeat (6*96 + 10) @(negedge CLK);
    for (int k = 0; k < 6; k++) begin
      chk_frame($sformatf("t3_frame%0d", k), 0, s0 + 96*k, {1'b0, b3[k]}, 8, 8, 1'b0, 1'b0, 3);
    end
    chk("t3_end_idle", log0_tx[s0+576], 1'b1);
    chk("t3_end_busy", log0_busy[s0+576], 1'b0);
    chk("t3_frames", fs0, 16'd10);
    chk("t3_level_empty", lvl0, 3'd0);

    // 4: reset at cycle 40 of a 0x00 frame while another byte waits
    push(0, 8'h00, s);
    push(0, 8'h77, s2);
    repeat (40) @(negedge CLK);
    chk("t4_pre_tx", tx0, 1'b0);
    chk("t4_pre_level", lvl0, 3'd1);
    resetn = 1'b0;
    #1;
    chk("t4_rst_tx", tx0, 1'b1);
    chk("t4_rst_level", lvl0, 3'd0);
    chk("t4_rst_frames", fs0, 16'd0);
    chk("t4_rst_busy", busy0, 1'b0);
    @(negedge CLK);
    resetn = 1'b1;
    @(negedge CLK);
    push(0, 8'hC3, s);
    repeat (100) @(negedge CLK);
    chk_frame("t4_frame", 0, s, 9'h0C3, 8, 8, 1'b0, 1'b0, 3);
    repeat (100) @(negedge CLK);
    chk("t4_frames", fs0, 16'd1);
    chk("t4_idle_busy", busy0, 1'b0);

    // 5: 2-bit counter wraps 1,2,3,0,1
    for (int n = 0; n < 5; n++) begin
      push(1, 8'h10 + 8'(n), s);
      repeat (100) @(negedge CLK);
      chk($sformatf("t5_frames%0d", n), fs1, fs_seq[n]);
    end

    // 6: 7 data bits, div 3, 1 stop, no gap: 0x55 -> 0,1,0,1,0,1,0,1,1 x 3 = 27
    parity_mode = 2'd0;
    push(2, 8'h55, s);
    repeat (32) @(negedge CLK);
    chk("t6_pre_idle", log2_tx[s-1], 1'b1);
    chk_frame("t6_frame", 2, s, 9'h055, 7, 3, 1'b0, 1'b0, 1);
    chk("t6_post_idle", log2_tx[s+27], 1'b1);
    chk("t6_frames", fs2, 16'd1);
    chk("t6_busy", busy2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
